sha256_block_sequencer: RTL and testbench
=========================================

// Module: sha256_block_sequencer
// PURPOSE
//  Drives the byte-wide register port of one sha256_core to hash a whole 512-bit block.
//  - Accepts the block on a valid/ready handshake.
//  - Resets the core, checks its identity, loads W memory and starts it.
//  - Waits for the core interrupt, reads the 256-bit digest back and returns it on a valid/ready handshake.
//  - Sits between the system bus logic and sha256_core; it is the only master of the core port.
// PARAMETERS
//  CRST_CYCLES    2     cycles o_core_rst_n is held low before each job (min 1)
//  TIMEOUT_CYCLES 255   max WAIT cycles for i_core_irq before timeout error (min 16)
//  WHO_AM_I_VAL   8'h07 expected core ID at core address 64
// PORTS
//  i_clk          in   1    clock; core shares it
//  i_rst          in   1    synchronous, active-high reset
//  i_blk_valid    in   1    block offered
//  o_blk_ready    out  1    sequencer can accept a block
//  i_blk          in   512  block; W0 in [511:480], W15 in [31:0]
//  o_digest_valid out  1    digest available
//  i_digest_ready in   1    consumer accepts digest
//  o_digest       out  256  digest; H0 in [255:224], H7 in [31:0]
//  o_err          out  1    sticky error flag
//  o_err_code     out  2    01 = ID mismatch, 10 = irq timeout
//  o_busy         out  1    state != IDLE
//  o_core_rst_n   out  1    core reset, active low
//  o_core_addr    out  7    core register address
//  o_core_data8   out  8    core write data
//  o_core_we      out  1    core write enable
//  i_core_data8   in   8    core read mux, combinational from o_core_addr
//  i_core_irq     in   1    core completed flag
// BEHAVIOUR
//  Reset values (i_rst high; synchronous, so any job is aborted mid-operation):
//  - state = IDLE; o_core_rst_n = 0 (follows i_rst).
//  - All other outputs 0; blk/digest regs 0; counters 0.
//  All core-port outputs are registered. Read data is sampled in the same cycle o_core_addr is presented.
//  FSM:
//  - IDLE:  o_blk_ready = 1. On i_blk_valid, latch i_blk, clear o_err/o_err_code -> CRST.
//  - CRST:  o_core_rst_n = 0 for CRST_CYCLES cycles -> IDCHK. The core restarts from HASH_INIT each job.
//  - IDCHK: addr = 64, we = 0, one cycle.
//           i_core_data8 != WHO_AM_I_VAL -> ERR(01); else -> LOAD.
//  - LOAD:  64 cycles, k = 0..63: addr = k, data = blk[8k+7:8k], we = 1 -> START.
//  - START: one cycle, addr = 65, data = 8'h01, we = 1 -> WAIT.
//  - WAIT:  addr = 65, we = 0, timer counts up from 0.
//           i_core_irq = 1 -> READ.
//           Timer reaching TIMEOUT_CYCLES without irq -> ERR(10).
//  - READ:  32 cycles, k = 0..31: addr = 70 + k, we = 0, digest[8k+7:8k] <= i_core_data8 -> CLEAR.
//  - CLEAR: one cycle, addr = 65, data = 8'h00, we = 1; returns core to INIT, drops irq -> DONE.
//  - DONE:  o_digest_valid = 1; o_digest stable. Leaves on i_digest_ready -> IDLE.
//           Backpressure is unlimited.
//  - ERR:   one cycle; o_err = 1, o_err_code set (sticky until next accepted block);
//           o_core_rst_n = 0 -> IDLE. No digest is delivered.
//  Boundary rules:
//  - o_blk_ready = 0 in every non-IDLE state; i_blk_valid is ignored outside IDLE.
//  - Same-cycle digest accept and new block offer: DONE -> IDLE first; the block is taken next cycle.
//  - o_core_we is never asserted in WAIT or READ.
//  - Address and byte counters are 7-bit and never wrap: terminal count forces the state change.
//  Job latency, handshake to o_digest_valid:
//  - CRST_CYCLES + 1 (IDCHK) + 64 (LOAD) + 1 (START) + W (WAIT, cycles until irq) + 32 (READ) + 1 (CLEAR).
// TESTING
//  1. Block "abc" (i_blk = 512'h61626380_0..._00000018), core model attached
//     -> o_digest = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad.
//  2. Two back-to-back "abc" blocks -> identical digests; o_core_rst_n pulsed low CRST_CYCLES cycles before each LOAD.
//  3. Core model returns 8'h05 at address 64 -> o_err = 1, o_err_code = 01, zero core writes, back in IDLE.
//  4. Core model never raises irq -> ERR after exactly TIMEOUT_CYCLES WAIT cycles (255 by default),
//     o_err_code = 10, o_digest_valid stays 0.
//  5. i_digest_ready held low 100 cycles in DONE -> o_digest_valid and o_digest stable;
//     o_blk_ready = 0 despite i_blk_valid = 1.
//  6. i_rst asserted during LOAD byte 30 -> next cycle all outputs at reset values;
//     a fresh block then hashes correctly.

Source files
------------

// File: rtl/sha256_block_sequencer_if.sv
// Block-in / digest-out handshake and status bundle between system logic and the SHA-256 sequencer.
// slave = sequencer side, master = system side that offers blocks and consumes digests.
interface sha256_block_sequencer_if;
  logic         i_blk_valid;
  logic         o_blk_ready;
  logic [511:0] i_blk;
  logic         o_digest_valid;
  logic         i_digest_ready;
  logic [255:0] o_digest;
  logic         o_err;
  logic [1:0]   o_err_code;
  logic         o_busy;

  modport slave (
    input  i_blk_valid, i_blk, i_digest_ready,
    output o_blk_ready, o_digest_valid, o_digest, o_err, o_err_code, o_busy
  );

  modport master (
    output i_blk_valid, i_blk, i_digest_ready,
    input  o_blk_ready, o_digest_valid, o_digest, o_err, o_err_code, o_busy
  );
endinterface

// File: rtl/sha256_block_sequencer.sv
// Drives one sha256_core byte port to hash a 512-bit block; latency CRST+66+W+33 cycles to digest.
// Blocks accepted only in IDLE; digest held in DONE for as long as the consumer stalls.
module sha256_block_sequencer #(
  parameter int         CRST_CYCLES    = 2,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] WHO_AM_I_VAL   = 8'h07
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  sha256_block_sequencer_if.slave        bus,
  output logic                           o_core_rst_n,
  output logic [6:0]                     o_core_addr,
  output logic [7:0]                     o_core_data8,
  output logic                           o_core_we,
  input  logic [7:0]                     i_core_data8,
  input  logic                           i_core_irq
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_CRST, ST_IDCHK, ST_LOAD, ST_START,
    ST_WAIT, ST_READ, ST_CLEAR, ST_DONE, ST_ERR
  } state_t;

  state_t         state_q, state_d;
  logic [6:0]     cnt_q, cnt_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [511:0]   blk_q, blk_d;
  logic [255:0]   digest_q, digest_d;
  logic           err_q, err_d;
  logic [1:0]     err_code_q, err_code_d;
  logic           blk_ready_q, blk_ready_d;
  logic           digest_valid_q, digest_valid_d;
  logic           busy_q, busy_d;
  logic           core_rst_n_q, core_rst_n_d;
  logic           we_q, we_d;
  logic [6:0]     addr_q, addr_d;
  logic [7:0]     data_q, data_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    blk_d      = blk_q;
    digest_d   = digest_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_blk_valid && blk_ready_q) begin
          blk_d      = bus.i_blk;
          err_d      = 1'b0;
          err_code_d = 2'b00;
          cnt_d      = 7'd0;
          state_d    = ST_CRST;
        end
      end
      ST_CRST: begin
        if (cnt_q == 7'(CRST_CYCLES - 1)) begin
          cnt_d   = 7'd0;
          state_d = ST_IDCHK;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_IDCHK: begin
        cnt_d = 7'd0;
        if (i_core_data8 != WHO_AM_I_VAL) begin
          err_d      = 1'b1;
          err_code_d = 2'b01;
          state_d    = ST_ERR;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (cnt_q == 7'd63) begin
          cnt_d   = 7'd0;
          state_d = ST_START;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_core_irq) begin
          cnt_d   = 7'd0;
          state_d = ST_READ;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
          state_d    = ST_ERR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_READ: begin
        // read mux is combinational on the registered address, so this byte belongs to cnt_q
        digest_d[{cnt_q[4:0], 3'b000} +: 8] = i_core_data8;
        if (cnt_q == 7'd31) begin
          cnt_d   = 7'd0;
          state_d = ST_CLEAR;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_CLEAR: state_d = ST_DONE;
      ST_DONE:  if (bus.i_digest_ready) state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered port matches the state it is in.
  always_comb begin
    blk_ready_d    = (state_d == ST_IDLE);
    busy_d         = (state_d != ST_IDLE);
    digest_valid_d = (state_d == ST_DONE);
    core_rst_n_d   = !((state_d == ST_CRST) || (state_d == ST_ERR));
    addr_d         = 7'd0;
    data_d         = 8'h00;
    we_d           = 1'b0;
    case (state_d)
      ST_IDCHK: addr_d = 7'd64;
      ST_LOAD: begin
        addr_d = cnt_d;
        data_d = blk_d[{cnt_d[5:0], 3'b000} +: 8];
        we_d   = 1'b1;
      end
      ST_START: begin
        addr_d = 7'd65;
        data_d = 8'h01;
        we_d   = 1'b1;
      end
      ST_WAIT:  addr_d = 7'd65;
      ST_READ:  addr_d = 7'd70 + cnt_d;
      ST_CLEAR: begin
        addr_d = 7'd65;
        data_d = 8'h00;
        we_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 7'd0;
      timer_q        <= '0;
      blk_q          <= '0;
      digest_q       <= '0;
      err_q          <= 1'b0;
      err_code_q     <= 2'b00;
      blk_ready_q    <= 1'b0;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      core_rst_n_q   <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= 7'd0;
      data_q         <= 8'h00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      timer_q        <= timer_d;
      blk_q          <= blk_d;
      digest_q       <= digest_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
      blk_ready_q    <= blk_ready_d;
      digest_valid_q <= digest_valid_d;
      busy_q         <= busy_d;
      core_rst_n_q   <= core_rst_n_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
    end
  end

  assign bus.o_blk_ready    = blk_ready_q;
  assign bus.o_digest_valid = digest_valid_q;
  assign bus.o_digest       = digest_q;
  assign bus.o_err          = err_q;
  assign bus.o_err_code     = err_code_q;
  assign bus.o_busy         = busy_q;
  assign o_core_rst_n       = core_rst_n_q;
  assign o_core_addr        = addr_q;
  assign o_core_data8       = data_q;
  assign o_core_we          = we_q;
endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Bench for sha256_block_sequencer with a behavioural sha256_core attached to its byte port.
module tb_sha256_block_sequencer;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  typedef struct packed {
    logic [511:0] blk;
    logic [7:0]   id;
    int           lat;
    bit           noirq;
    int           hold;
    bit           exp_err;
    logic [1:0]   exp_code;
    bit           exp_valid;
    logic [255:0] exp_dig;
    int           exp_wait;
    int           exp_writes;
    int           exp_rstlow;
  } vec_t;

  logic clk = 1'b0;
  logic i_rst;
  logic core_rst_n, core_we, core_irq;
  logic [6:0] core_addr;
  logic [7:0] core_wdata, core_rdata;
  int checks = 0;
  int errors = 0;
  vec_t vecs [6];

  sha256_block_sequencer_if bus_if();

  sha256_block_sequencer dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .bus          (bus_if),
    .o_core_rst_n (core_rst_n),
    .o_core_addr  (core_addr),
    .o_core_data8 (core_wdata),
    .o_core_we    (core_we),
    .i_core_data8 (core_rdata),
    .i_core_irq   (core_irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural core ----------------
  logic [31:0] k_tab [64];
  logic [7:0]  wmem [64];
  logic [255:0] core_dig;
  logic [7:0] cfg_id;
  int cfg_lat;
  bit cfg_noirq;
  int core_tmr;
  bit core_run;

  initial k_tab = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha256_blk(input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] h [8];
    logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2;
    h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    a = h[0]; bb = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k_tab[i] + w[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {h[0] + a, h[1] + bb, h[2] + c, h[3] + d, h[4] + e, h[5] + f, h[6] + g, h[7] + hh};
  endfunction

  function automatic logic [511:0] pack_wmem();
    logic [511:0] r;
    for (int k = 0; k < 64; k++) r[8*k +: 8] = wmem[k];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!core_rst_n) begin
      core_irq <= 1'b0;
      core_run <= 1'b0;
      core_tmr <= 0;
      core_dig <= '0;
      for (int k = 0; k < 64; k++) wmem[k] <= 8'h00;
    end else begin
      if (core_we && core_addr < 7'd64) wmem[core_addr[5:0]] <= core_wdata;
      if (core_we && core_addr == 7'd65 && core_wdata == 8'h01) begin
        core_dig <= sha256_blk(pack_wmem());
        core_tmr <= cfg_lat;
        core_run <= 1'b1;
      end else if (core_we && core_addr == 7'd65 && core_wdata == 8'h00) begin
        core_irq <= 1'b0;
        core_run <= 1'b0;
      end else if (core_run) begin
        if (core_tmr <= 1) begin
          core_run <= 1'b0;
          core_irq <= !cfg_noirq;
        end else begin
          core_tmr <= core_tmr - 1;
        end
      end
    end
  end

  always_comb begin
    logic [6:0] ra;
    ra = core_addr - 7'd70;
    core_rdata = 8'h00;
    if (core_addr < 7'd64) core_rdata = wmem[core_addr[5:0]];
    else if (core_addr == 7'd64) core_rdata = cfg_id;
    else if (core_addr == 7'd65) core_rdata = {7'd0, core_irq};
    else if (core_addr >= 7'd70 && core_addr < 7'd102) core_rdata = core_dig[{ra[4:0], 3'b000} +: 8];
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_flags"}, {bus_if.o_blk_ready, bus_if.o_digest_valid, bus_if.o_err, bus_if.o_err_code,
                             bus_if.o_busy, core_rst_n, core_we}, 0);
    check({tag, "_addr_data"}, {core_addr, core_wdata}, 0);
    check({tag, "_digest"}, bus_if.o_digest, 0);
  endtask

  task automatic monitor_job(input vec_t v, input int hold, output bit chained);
    int n, first_valid, waitc, writes, rstlow;
    bit dv_seen, stable;
    n = 0; first_valid = 0; waitc = 0; writes = 0; rstlow = 0; dv_seen = 0; chained = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("first_cycle_ready_busy", {bus_if.o_blk_ready, bus_if.o_busy}, 2'b01);
        bus_if.i_blk_valid = 1'b0;
      end
      if (core_we) writes++;
      if (!core_rst_n) rstlow++;
      if (bus_if.o_busy && core_addr == 7'd65 && !core_we) waitc++;
      if (bus_if.o_digest_valid) begin
        dv_seen = 1; first_valid = n;
        break;
      end
      if (!bus_if.o_busy) break;
    end
    check("job_bounded", n < 2000, 1);
    check("digest_valid", dv_seen, v.exp_valid);
    check("err", {bus_if.o_err, bus_if.o_err_code}, {v.exp_err, v.exp_code});
    check("wait_cycles", waitc, v.exp_wait);
    check("core_writes", writes, v.exp_writes);
    check("core_rst_low", rstlow, v.exp_rstlow);
    if (v.exp_err) check("idle_after_err", {bus_if.o_blk_ready, bus_if.o_busy}, 2'b10);
    if (dv_seen) begin
      check("latency", first_valid - 1, 101 + v.exp_wait);
      check("digest", bus_if.o_digest, v.exp_dig);
      bus_if.i_blk_valid = (hold > 0);
      stable = 1;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        if (!(bus_if.o_digest_valid && bus_if.o_digest == v.exp_dig && !bus_if.o_blk_ready && bus_if.o_busy))
          stable = 0;
      end
      if (hold > 0) check("done_hold_stable", stable, 1);
      bus_if.i_digest_ready = 1'b1;
      @(negedge clk);
      bus_if.i_digest_ready = 1'b0;
      check("done_exit", {bus_if.o_digest_valid, bus_if.o_blk_ready, bus_if.o_busy}, 3'b010);
      chained = (hold > 0);
    end
  endtask

  task automatic run_job(input int idx);
    vec_t v;
    int n;
    bit chained;
    v = vecs[idx];
    cfg_id = v.id; cfg_lat = v.lat; cfg_noirq = v.noirq;
    bus_if.i_blk = v.blk;
    bus_if.i_blk_valid = 1'b1;
    n = 0;
    while (!bus_if.o_blk_ready && n < 200) begin @(negedge clk); n++; end
    check("blk_ready_wait", n < 200, 1);
    @(posedge clk);
    monitor_job(v, v.hold, chained);
    while (chained) begin
      @(posedge clk);
      monitor_job(v, 0, chained);
    end
  endtask

  initial begin
    int n;
    bit chained;
    //            blk        id     lat noirq hold err code   vld dig        wait wr  rstlow
    vecs[0] = '{ABC_BLK,   8'h07,  5, 1'b0,   0, 1'b0, 2'b00, 1'b1, ABC_DIG,     6, 66, 2};
    vecs[1] = '{ABC_BLK,   8'h07, 40, 1'b0,   0, 1'b0, 2'b00, 1'b1, ABC_DIG,    41, 66, 2};
    vecs[2] = '{EMPTY_BLK, 8'h07,  1, 1'b0,   0, 1'b0, 2'b00, 1'b1, EMPTY_DIG,   2, 66, 2};
    vecs[3] = '{ABC_BLK,   8'h05,  5, 1'b0,   0, 1'b1, 2'b01, 1'b0, 256'h0,      0,  0, 3};
    vecs[4] = '{ABC_BLK,   8'h07,  5, 1'b1,   0, 1'b1, 2'b10, 1'b0, 256'h0,    255, 65, 3};
    vecs[5] = '{ABC_BLK,   8'h07, 10, 1'b0, 100, 1'b0, 2'b00, 1'b1, ABC_DIG,    11, 66, 2};

    i_rst = 1'b1;
    bus_if.i_blk_valid = 1'b0;
    bus_if.i_blk = '0;
    bus_if.i_digest_ready = 1'b0;
    cfg_id = 8'h07; cfg_lat = 5; cfg_noirq = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    i_rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(i);

    // reset in the middle of LOAD, then a fresh job
    cfg_id = 8'h07; cfg_lat = 5; cfg_noirq = 1'b0;
    bus_if.i_blk = ABC_BLK;
    bus_if.i_blk_valid = 1'b1;
    n = 0;
    while (!bus_if.o_blk_ready && n < 200) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    bus_if.i_blk_valid = 1'b0;
    n = 0;
    while (!(core_we && core_addr == 7'd30) && n < 200) begin @(negedge clk); n++; end
    check("reach_load_byte30", n < 200, 1);
    i_rst = 1'b1;
    @(negedge clk);
    check_reset("mid_load_reset");
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    run_job(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
